// File: rtl/reflet_multi_counter.sv
// reflet_multi_counter: multi-channel programmable counter/timer.
// Every channel counts from 0 up to its own (max-1) terminal value and then
// emits a one-cycle pulse on out. The channel runs periodically, or in one-shot
// mode it returns to IDLE. A global enable gates every channel.
// Optional feature macro: REFLET_COUNTER_PRESCALER_EN. It adds one shared
// prescaler that divides the count tick by (prescale+1).
module reflet_multi_counter #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4
`ifdef REFLET_COUNTER_PRESCALER_EN
   ,
   parameter int PRESCALE_WIDTH = 8
`endif
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [CHANNELS-1:0]       start,
   input  logic [CHANNELS-1:0]       stop,
   input  logic [CHANNELS-1:0]       oneshot,
   input  logic [CHANNELS*WIDTH-1:0] max,
`ifdef REFLET_COUNTER_PRESCALER_EN
   input  logic [PRESCALE_WIDTH-1:0] prescale,
`endif
   output logic [CHANNELS-1:0]       out,
   output logic [CHANNELS-1:0]       busy,
   output logic [CHANNELS*WIDTH-1:0] count
);

   localparam logic [0:0]       IDLE    = 1'b0;
   localparam logic [0:0]       RUN     = 1'b1;
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1'b1);

   logic tick_s;

`ifdef REFLET_COUNTER_PRESCALER_EN
   localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE = PRESCALE_WIDTH'(1'b1);

   logic [PRESCALE_WIDTH-1:0] pre_cnt_r;
   logic                      pre_wrap_s;

   // The prescaler wraps when it reaches prescale; that wrap is the count tick.
   always_comb begin
      pre_wrap_s = (pre_cnt_r == prescale);
      tick_s     = enable & pre_wrap_s;
   end

   // Free-running shared prescaler. It is cleared while enable is low and start does not touch it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pre_cnt_r <= {PRESCALE_WIDTH{1'b0}};
      end else if (!enable) begin
         pre_cnt_r <= {PRESCALE_WIDTH{1'b0}};
      end else if (pre_wrap_s) begin
         pre_cnt_r <= {PRESCALE_WIDTH{1'b0}};
      end else begin
         pre_cnt_r <= pre_cnt_r + PRE_ONE;
      end
   end
`else
   // Without a prescaler, every enabled cycle is a count tick.
   always_comb begin
      tick_s = enable;
   end
`endif

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [0:0]       state_r;
      logic [0:0]       state_nxt_s;
      logic [WIDTH-1:0] cnt_r;
      logic [WIDTH-1:0] cnt_nxt_s;
      logic [WIDTH-1:0] term_s;
      logic             at_term_s;
      logic             pulse_r;
      logic             pulse_nxt_s;
      logic             busy_r;

      // Terminal is max-1 modulo 2^WIDTH, so max=0 gives a full 2^WIDTH period.
      always_comb begin
         term_s    = max[c*WIDTH +: WIDTH] - CNT_ONE;
         at_term_s = (cnt_r == term_s);
      end

      // Next-state logic with priority start > stop > count.
      always_comb begin
         state_nxt_s = state_r;
         cnt_nxt_s   = cnt_r;
         pulse_nxt_s = 1'b0;
         if (start[c]) begin
            cnt_nxt_s   = {WIDTH{1'b0}};
            state_nxt_s = RUN;
         end else if (stop[c]) begin
            cnt_nxt_s   = {WIDTH{1'b0}};
            state_nxt_s = IDLE;
         end else begin
            case (state_r)
               IDLE: begin
                  cnt_nxt_s   = {WIDTH{1'b0}};
                  state_nxt_s = IDLE;
               end
               RUN: begin
                  if (tick_s) begin
                     if (at_term_s) begin
                        cnt_nxt_s   = {WIDTH{1'b0}};
                        pulse_nxt_s = 1'b1;
                        state_nxt_s = oneshot[c] ? IDLE : RUN;
                     end else begin
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                        state_nxt_s = RUN;
                     end
                  end else begin
                     cnt_nxt_s   = cnt_r;
                     state_nxt_s = RUN;
                  end
               end
               default: begin
                  cnt_nxt_s   = {WIDTH{1'b0}};
                  state_nxt_s = IDLE;
               end
            endcase
         end
      end

      // Channel state, count, pulse and busy registers.
      always_ff @(posedge clk) begin
         if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= {WIDTH{1'b0}};
            pulse_r <= 1'b0;
            busy_r  <= 1'b0;
         end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            pulse_r <= pulse_nxt_s;
            busy_r  <= (state_nxt_s == RUN);
         end
      end

      assign out[c]                  = pulse_r;
      assign busy[c]                 = busy_r;
      assign count[c*WIDTH +: WIDTH] = cnt_r;
   end

endmodule

// File: tb/tb_reflet_multi_counter.sv
// Testbench for reflet_multi_counter (WIDTH=8, CHANNELS=4). Stimulus pushes the
// expected pulse edges into per-channel queues. A monitor pops and compares them
// whenever out is high. Compile with REFLET_COUNTER_PRESCALER_EN to include the
// prescaler case.
module tb_reflet_multi_counter;
   localparam int W  = 8;
   localparam int CH = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            enable;
   logic [CH-1:0]   start;
   logic [CH-1:0]   stop;
   logic [CH-1:0]   oneshot;
   logic [CH*W-1:0] max;
   logic [CH-1:0]   out;
   logic [CH-1:0]   busy;
   logic [CH*W-1:0] count;
`ifdef REFLET_COUNTER_PRESCALER_EN
   logic [7:0]      prescale;
`endif

   int n_cmp  = 0;
   int n_err  = 0;
   int edge_n = 0;
   int exp_q[CH][$];

   reflet_multi_counter #(
      .WIDTH(W),
      .CHANNELS(CH)
`ifdef REFLET_COUNTER_PRESCALER_EN
      ,
      .PRESCALE_WIDTH(8)
`endif
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .start(start),
      .stop(stop),
      .oneshot(oneshot),
      .max(max),
`ifdef REFLET_COUNTER_PRESCALER_EN
      .prescale(prescale),
`endif
      .out(out),
      .busy(busy),
      .count(count)
   );

   always #5 clk = ~clk;

   // Edge counter: after rising edge E, the following falling edge sees edge_n == E.
   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   task automatic wait_to(input int e);
      while (edge_n < e) @(negedge clk);
   endtask

   // Scoreboard monitor: each out pulse must match the head of its channel's queue.
   always @(negedge clk) begin
      for (int c = 0; c < CH; c++) begin
         if (out[c]) begin
            n_cmp++;
            if (exp_q[c].size() > 0 && exp_q[c][0] == edge_n) begin
               void'(exp_q[c].pop_front());
            end else begin
               n_err++;
               $display("FAIL out%0d_pulse: got pulse at edge %0d, expected none", c, edge_n);
            end
         end
         while (exp_q[c].size() > 0 && exp_q[c][0] < edge_n) begin
            n_cmp++;
            n_err++;
            $display("FAIL out%0d_pulse: got no pulse, expected one at edge %0d", c, exp_q[c][0]);
            void'(exp_q[c].pop_front());
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int t2;
      reset = 1'b0; enable = 1'b0; start = '0; stop = '0; oneshot = '0; max = '0;
`ifdef REFLET_COUNTER_PRESCALER_EN
      prescale = 8'd0;
`endif
      repeat (2) @(negedge clk);
      check("rst_out",   32'(out),   32'd0);
      check("rst_busy",  32'(busy),  32'd0);
      check("rst_count", 32'(count), 32'd0);
      reset = 1'b1; enable = 1'b1;

      // Periodic ch0, max=5
      max[7:0] = 8'd5;
      start = 4'b0001; @(negedge clk); start = '0; t = edge_n;
      for (int k = 1; k <= 3; k++) exp_q[0].push_back(t + 5*k);
      check("p_busy0_start",  32'(busy[0]),    32'd1);
      check("p_count0_start", 32'(count[7:0]), 32'd0);
      wait_to(t + 2);  check("p_count0_2", 32'(count[7:0]), 32'd2);
      wait_to(t + 7);  check("p_count0_7", 32'(count[7:0]), 32'd2);
      check("p_busy0_run", 32'(busy[0]), 32'd1);
      wait_to(t + 15);
      stop = 4'b0001; @(negedge clk); stop = '0;
      check("p_busy0_stop",  32'(busy[0]),    32'd0);
      check("p_count0_stop", 32'(count[7:0]), 32'd0);

      // One-shot ch1, max=3
      max[15:8] = 8'd3; oneshot = 4'b0010;
      start = 4'b0010; @(negedge clk); start = '0; t = edge_n;
      exp_q[1].push_back(t + 3);
      wait_to(t + 2); check("os_busy1_2",  32'(busy[1]),     32'd1);
                      check("os_count1_2", 32'(count[15:8]), 32'd2);
      wait_to(t + 3); check("os_busy1_3",  32'(busy[1]),     32'd0);
                      check("os_count1_3", 32'(count[15:8]), 32'd0);
      wait_to(t + 8); check("os_busy1_8",  32'(busy[1]),     32'd0);
                      check("os_count1_8", 32'(count[15:8]), 32'd0);

      // ch2 max=1 (every tick), ch3 max=0 (period 256)
      oneshot = '0; max[23:16] = 8'd1; max[31:24] = 8'd0;
      start = 4'b1100; @(negedge clk); start = '0; t = edge_n;
      for (int k = 1; k <= 6; k++) exp_q[2].push_back(t + k);
      exp_q[3].push_back(t + 256);
      wait_to(t + 6);
      stop = 4'b0100; @(negedge clk); stop = '0;   // stop lands on a terminal edge
      check("m1_busy2_stop",  32'(busy[2]),      32'd0);
      check("m1_count2_stop", 32'(count[23:16]), 32'd0);
      check("m0_busy3",       32'(busy[3]),      32'd1);
      wait_to(t + 255); check("m0_count3_255", 32'(count[31:24]), 32'd255);
      wait_to(t + 256); check("m0_count3_256", 32'(count[31:24]), 32'd0);
                        check("m0_busy3_256",  32'(busy[3]),      32'd1);
      stop = 4'b1000; @(negedge clk); stop = '0;

      // Enable gating: 4 frozen cycles stretch ch0's first period to 9
      start = 4'b0001; @(negedge clk); start = '0; t = edge_n;
      exp_q[0].push_back(t + 9); exp_q[0].push_back(t + 14);
      wait_to(t + 2); enable = 1'b0;
      wait_to(t + 6); check("en_count0_frozen", 32'(count[7:0]), 32'd2);
      enable = 1'b1;
      wait_to(t + 14);
      stop = 4'b0001; @(negedge clk); stop = '0;

      // start+stop together: restart
      start = 4'b0001; @(negedge clk); start = '0; t = edge_n;
      wait_to(t + 2);
      start = 4'b0001; stop = 4'b0001; @(negedge clk); start = '0; stop = '0; t2 = edge_n;
      check("ss_count0", 32'(count[7:0]), 32'd0);
      check("ss_busy0",  32'(busy[0]),    32'd1);
      exp_q[0].push_back(t2 + 5);
      wait_to(t2 + 5);
      stop = 4'b0001; @(negedge clk); stop = '0;

      // Reset mid-run
      start = 4'b0001; @(negedge clk); start = '0; t = edge_n;
      wait_to(t + 3); check("rm_count0_3", 32'(count[7:0]), 32'd3);
      reset = 1'b0; @(negedge clk);
      check("rm_out",   32'(out),   32'd0);
      check("rm_busy",  32'(busy),  32'd0);
      check("rm_count", 32'(count), 32'd0);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      check("rm_busy_after",  32'(busy),  32'd0);
      check("rm_count_after", 32'(count), 32'd0);

`ifdef REFLET_COUNTER_PRESCALER_EN
      // Prescaler: prescale=2, max=4 -> period 12; first pulse 11 edges after start
      max[7:0] = 8'd4; prescale = 8'd2;
      enable = 1'b0; @(negedge clk);
      enable = 1'b1; start = 4'b0001; @(negedge clk); start = '0; t = edge_n;
      exp_q[0].push_back(t + 11); exp_q[0].push_back(t + 23);
      wait_to(t + 10); check("ps_count0_10", 32'(count[7:0]), 32'd3);
      wait_to(t + 23);
      stop = 4'b0001; @(negedge clk); stop = '0;
      prescale = 8'd0;
`endif

      repeat (5) @(negedge clk);
      for (int c = 0; c < CH; c++) check($sformatf("queue%0d_empty", c), 32'(exp_q[c].size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/reflet_multi_counter.md
# reflet_multi_counter

Multi-channel, parametrised programmable counter/timer for the Reflet microcontroller peripheral set. Each channel counts up to its own terminal value and emits a one-cycle pulse, in periodic or one-shot mode, with explicit start/stop control and a readable count. A shared global enable gates every channel. The block drives PWM, timer-interrupt and baud-tick generators from a single instance.

## Interface

- `WIDTH`, 32: counter and terminal-value width per channel.
- `CHANNELS`, 4: number of independent channels, ≥1.
- `clk` in 1: clock; all logic on rising edge.
- `reset` in 1: synchronous, active-low reset.
- `enable` in 1: global count enable; low freezes every channel's state and count.
- `start` in CHANNELS: per-channel start/restart request, sampled each edge.
- `stop` in CHANNELS: per-channel stop request, sampled each edge.
- `oneshot` in CHANNELS: 1 = one-shot mode, 0 = periodic; sampled at terminal.
- `max` in CHANNELS*WIDTH: terminal value; channel c at `[c*WIDTH +: WIDTH]`; live, not latched.
- `out` out CHANNELS: one-cycle terminal pulse per channel.
- `busy` out CHANNELS: channel in RUN.
- `count` out CHANNELS*WIDTH: current counter value, same packing as `max`.

## Operation

- Per-channel FSM with states IDLE and RUN; channels are fully independent.
- Reset (`reset`=0 at edge): all channels go to IDLE; counter, `out`, `busy` all 0.
- Priority at each edge, per channel: reset > start > stop > count.
- `start`=1: counter←0, state←RUN, `out`←0; this applies from either state and restarts a running channel.
- `stop`=1 with `start`=0: counter←0, state←IDLE, `out`←0.
- IDLE: counter holds 0, `out`=0, and `enable` is ignored.
- RUN with tick=1 (tick = `enable` without the prescaler):
  - counter == `max`−1 (WIDTH-bit modular): counter←0, `out`←1, state←IDLE if `oneshot`=1, else stays RUN.
  - Otherwise: counter←counter+1 (wraps at 2^WIDTH), `out`←0.
- RUN with tick=0: counter and state hold, `out`←0. `out` is never high for two consecutive cycles unless the channel terminates on consecutive ticks.
- `max`=1: every tick is terminal.
- `max`=0: the terminal value is 2^WIDTH−1, giving a period of 2^WIDTH.
- If `max` is lowered below the current count, the counter runs on to the 2^WIDTH wrap before matching. There is no early terminal.
- A `start` or `stop` in the same cycle as a terminal condition suppresses the pulse.
- `busy` = state==RUN. It is registered and updates on the same edge as the state.

## Timing

- All outputs are registered; there is no combinational input-to-output path.
- `start` at edge 0 with `enable` held high gives `out`=1 after edge `max`, i.e. latency `max` cycles. Periodic pulses then repeat every `max` cycles.
- One-shot: `busy` falls on the same edge that `out` rises.
- `count` reflects the value after each edge.
- `enable` low for k cycles stretches the period by exactly k cycles.

## Configuration

- `REFLET_COUNTER_PRESCALER_EN` defined:
  - Adds parameter `PRESCALE_WIDTH` (default 8) and input `prescale` [PRESCALE_WIDTH].
  - A single shared prescaler counter advances when `enable`=1. On reaching `prescale` it wraps to 0 and asserts tick for one cycle, so tick = `enable` AND prescaler-wrap.
  - Period becomes `max`·(`prescale`+1) cycles. With `prescale`=0 the behaviour is identical to the macro being absent.
  - The prescaler resets to 0 and holds while `enable`=0. It is free-running, so `start` does not resynchronise it.
- Macro absent: no prescaler logic or port; tick = `enable`.

## Test plan

- Reset then periodic run: `reset` low 2 cycles, then ch0 `max`=5, `oneshot`=0, `enable`=1, `start` pulse → `out[0]` high 5 cycles after start, then every 5 cycles; `busy[0]`=1 throughout.
- One-shot: ch1 `max`=3, `oneshot`=1, start → single `out[1]` pulse 3 cycles later; `busy[1]` falls on the same edge; `count[1]`=0 thereafter.
- Boundaries: ch2 `max`=1 → `out[2]` every cycle. ch3 `max`=0 with WIDTH=8 → period 256.
- Enable gating and priority:
  - `enable` low for 4 cycles mid-count → period stretched to `max`+4.
  - `start`+`stop` in the same cycle → restart.
  - `stop` on the terminal cycle → no pulse, `busy`=0.
- Reset mid-run: assert `reset` with `count`=3 → next cycle all `count`=0, `busy`=0, `out`=0, and no pulse after reset is released.
- Prescaler (macro defined): `prescale`=2, `max`=4 → `out` period 12 cycles. `prescale`=0 → waveform matches the macro-absent build.
